// File: rtl/arb_pkg.sv
// Shared types and constants for the arbitrated bus requester.
package arb_pkg;

  localparam int ADDR_W      = 8;
  localparam int LEN_W       = 4;
  localparam int BACKOFF_LEN = 2;
  localparam int CMD_W       = ADDR_W + LEN_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_RELEASE,
    S_BACKOFF
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } cmd_t;

  // Beat address wraps modulo 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [LEN_W-1:0]  idx);
    return base + {{(ADDR_W-LEN_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command queue: first-word-fall-through FIFO with full/empty flags.
module cmd_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  // A push while full is dropped; a pop while empty is ignored.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care while the queue is empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/arb_requester.sv
// Bus requester: queues burst commands, arbitrates for the shared address
// bus, drives incrementing beat addresses, and backs off on grant timeout.
module arb_requester
  import arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              req,
  input  logic              gnt,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_oe,
  output logic              beat,
  output logic              done,
  output logic              err_timeout,
  output logic              err_abort
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [1:0] BO_LAST   = 2'(BACKOFF_LEN - 1);

  state_t           state;
  logic [7:0]       wait_cnt;
  logic [1:0]       bo_cnt;
  logic [LEN_W-1:0] idx;
  logic [CMD_W-1:0] head_bits;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  assign head      = head_bits;
  assign cmd_ready = !fifo_full;
  // The head leaves the queue only when its final beat completes under grant.
  assign pop       = (state == S_XFER) && gnt && (idx == head.len);

  cmd_fifo #(
    .DATA_W (CMD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (cmd_valid),
    .pop     (pop),
    .wr_data ({cmd_addr, cmd_len}),
    .rd_data (head_bits),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Request/transfer FSM with registered bus, handshake and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      bo_cnt      <= '0;
      idx         <= '0;
      req         <= 1'b0;
      addr_oe     <= 1'b0;
      beat        <= 1'b0;
      addr_out    <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_abort   <= 1'b0;
    end else begin
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_abort   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state    <= S_REQ;
            req      <= 1'b1;
            wait_cnt <= '0;
          end
        end
        S_REQ: begin
          // A grant on the last waiting cycle still wins over the timeout.
          if (gnt) begin
            state    <= S_XFER;
            idx      <= '0;
            addr_oe  <= 1'b1;
            beat     <= 1'b1;
            addr_out <= head.addr;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= S_BACKOFF;
            req         <= 1'b0;
            err_timeout <= 1'b1;
            bo_cnt      <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_XFER: begin
          if (!gnt) begin
            state     <= S_RELEASE;
            req       <= 1'b0;
            addr_oe   <= 1'b0;
            beat      <= 1'b0;
            addr_out  <= '0;
            err_abort <= 1'b1;
          end else if (idx == head.len) begin
            state    <= S_RELEASE;
            req      <= 1'b0;
            addr_oe  <= 1'b0;
            beat     <= 1'b0;
            addr_out <= '0;
            done     <= 1'b1;
          end else begin
            idx      <= idx + LEN_W'(1);
            addr_out <= beat_addr(head.addr, idx + LEN_W'(1));
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
        end
        S_BACKOFF: begin
          if (bo_cnt == BO_LAST) begin
            state    <= S_REQ;
            req      <= 1'b1;
            wait_cnt <= '0;
          end else begin
            bo_cnt <= bo_cnt + 2'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_arb_requester;

  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [3:0] cmd_len = 4'h0;
  logic       gnt = 1'b0;
  logic       cmd_ready, req, addr_oe, beat, done, err_timeout, err_abort;
  logic [7:0] addr_out;

  always #5 clock = ~clock;

  arb_requester #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .req         (req),
    .gnt         (gnt),
    .addr_out    (addr_out),
    .addr_oe     (addr_oe),
    .beat        (beat),
    .done        (done),
    .err_timeout (err_timeout),
    .err_abort   (err_abort)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0] addr;
    logic [3:0] len;
  } mcmd_t;

  mcmd_t      mq[$];
  int         m_ph;      // 0 idle, 1 requesting, 2 transferring, 3 release gap, 4 backing off
  int         m_waited;  // cycles spent requesting so far
  int         m_sent;    // index of the beat on the bus
  int         m_bo;      // back-off cycles remaining
  logic       e_req, e_oe, e_done, e_to, e_ab;
  logic [7:0] e_addr;

  task automatic model_reset();
    mq.delete();
    m_ph = 0; m_waited = 0; m_sent = 0; m_bo = 0;
    e_req = 0; e_oe = 0; e_done = 0; e_to = 0; e_ab = 0; e_addr = 8'h00;
  endtask

  task automatic model_step();
    int    old_size;
    mcmd_t nc;
    old_size = mq.size();
    e_done = 0; e_to = 0; e_ab = 0;
    case (m_ph)
      0: if (old_size > 0) begin m_ph = 1; m_waited = 0; end
      1: begin
        m_waited++;
        if (gnt) begin m_ph = 2; m_sent = 0; end
        else if (m_waited == TMO) begin m_ph = 4; m_bo = 2; e_to = 1; end
      end
      2: begin
        if (!gnt) begin m_ph = 3; e_ab = 1; end
        else if (m_sent == int'(mq[0].len)) begin void'(mq.pop_front()); e_done = 1; m_ph = 3; end
        else m_sent++;
      end
      3: m_ph = 0;
      default: begin
        m_bo--;
        if (m_bo == 0) begin m_ph = 1; m_waited = 0; end
      end
    endcase
    if (cmd_valid && old_size < DEPTH) begin
      nc.addr = cmd_addr;
      nc.len  = cmd_len;
      mq.push_back(nc);
    end
    e_req  = (m_ph == 1) || (m_ph == 2);
    e_oe   = (m_ph == 2);
    e_addr = e_oe ? 8'(int'(mq[0].addr) + m_sent) : 8'h00;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clock);
      check("cycle",
            {17'd0, cmd_ready, req, addr_oe, beat, done, err_timeout, err_abort, addr_out},
            {17'd0, 1'(mq.size() < DEPTH), e_req, e_oe, e_oe, e_done, e_to, e_ab, e_addr});
    end
  end

  // ---------------- observation log for directed checks ----------------
  logic [7:0] blog[$];
  int done_cnt = 0, to_cnt = 0, ab_cnt = 0, run = 0, last_run = 0;

  initial begin
    forever begin
      @(negedge clock);
      if (beat) blog.push_back(addr_out);
      if (done) done_cnt++;
      if (err_timeout) to_cnt++;
      if (err_abort) ab_cnt++;
      if (req) run++;
      else begin
        if (run > 0) last_run = run;
        run = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [3:0] l);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int k = 0;
    while (!req && k < 60) begin tick(); k++; end
    check({nm, "_req_seen"}, req, 1);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int start = done_cnt;
    int k = 0;
    while (done_cnt == start && k < budget) begin tick(); k++; end
    check({nm, "_done_seen"}, done_cnt - start, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int k;
    int d0, t0;
    logic [7:0] exp_a;

    // Reset state
    tick();
    check("rst_req", req, 0);
    check("rst_oe", addr_oe, 0);
    check("rst_addr", addr_out, 0);
    check("rst_ready", cmd_ready, 1);
    do_reset();

    // Three-beat burst, grant two cycles after request
    blog.delete();
    push(8'h10, 4'd2);
    wait_req("t1");
    tick();
    gnt = 1'b1;
    wait_done("t1", 20);
    check("t1_req_at_done", req, 0);
    gnt = 1'b0;
    check("t1_nbeats", blog.size(), 3);
    check("t1_b0", blog[0], 8'h10);
    check("t1_b1", blog[1], 8'h11);
    check("t1_b2", blog[2], 8'h12);
    tick();
    check("t1_gap_req", req, 0);

    // Address wraps at 8 bits
    blog.delete();
    push(8'hFE, 4'd3);
    wait_req("t2");
    gnt = 1'b1;
    wait_done("t2", 20);
    gnt = 1'b0;
    check("t2_nbeats", blog.size(), 4);
    check("t2_b0", blog[0], 8'hFE);
    check("t2_b1", blog[1], 8'hFF);
    check("t2_b2", blog[2], 8'h00);
    check("t2_b3", blog[3], 8'h01);

    // Grant timeout, back-off, re-request, completion
    blog.delete();
    t0 = to_cnt;
    push(8'h20, 4'd0);
    k = 0;
    while (to_cnt == t0 && k < 40) begin tick(); k++; end
    check("t3_timeout", to_cnt - t0, 1);
    check("t3_req_cycles", last_run, TMO);
    check("t3_bo1_req", req, 0);
    tick();
    check("t3_bo2_req", req, 0);
    tick();
    check("t3_rereq", req, 1);
    gnt = 1'b1;
    wait_done("t3", 20);
    gnt = 1'b0;
    check("t3_nbeats", blog.size(), 1);
    check("t3_b0", blog[0], 8'h20);

    // Grant lost after four beats, restart from base
    blog.delete();
    push(8'h40, 4'd7);
    wait_req("t4");
    gnt = 1'b1;
    k = 0;
    while (blog.size() < 4 && k < 30) begin tick(); k++; end
    gnt = 1'b0;
    tick();
    check("t4_abort", err_abort, 1);
    check("t4_oe_off", addr_oe, 0);
    check("t4_beat_off", beat, 0);
    check("t4_partial", blog.size(), 4);
    blog.delete();
    wait_req("t4b");
    gnt = 1'b1;
    wait_done("t4", 30);
    gnt = 1'b0;
    check("t4_nbeats", blog.size(), 8);
    check("t4_first", blog[0], 8'h40);
    check("t4_last", blog[7], 8'h47);

    // Queue fills at four; fifth push is dropped; FIFO completion order
    blog.delete();
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_addr  = 8'(8'h80 + i * 16);
      cmd_len   = 4'd1;
      tick();
      if (i == 2) check("t5_ready_3", cmd_ready, 1);
      if (i == 3) check("t5_ready_full", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    check("t5_ready_after5", cmd_ready, 0);
    gnt = 1'b1;
    k = 0;
    while (done_cnt - d0 < 4 && k < 300) begin tick(); k++; end
    check("t5_ndone", done_cnt - d0, 4);
    repeat (20) tick();
    gnt = 1'b0;
    check("t5_nbeats", blog.size(), 8);
    for (int i = 0; i < 8; i++) begin
      exp_a = 8'(8'h80 + (i / 2) * 16 + (i % 2));
      check($sformatf("t5_b%0d", i), blog[i], exp_a);
    end
    check("t5_ready_end", cmd_ready, 1);

    // Asynchronous reset during the second beat
    blog.delete();
    push(8'h50, 4'd3);
    push(8'h60, 4'd0);
    wait_req("t6");
    gnt = 1'b1;
    k = 0;
    while (blog.size() < 2 && k < 30) begin tick(); k++; end
    #2;
    reset = 1'b1;
    #1;
    check("t6_oe", addr_oe, 0);
    check("t6_beat", beat, 0);
    check("t6_req", req, 0);
    check("t6_addr", addr_out, 0);
    check("t6_ready", cmd_ready, 1);
    tick();
    reset = 1'b0;
    repeat (20) tick();
    gnt = 1'b0;
    check("t6_no_more_beats", blog.size(), 2);
    check("t6_idle_req", req, 0);

    // Randomized traffic checked every cycle against the model
    for (int c = 0; c < 3000; c++) begin
      cmd_valid = ($urandom % 3 == 0);
      cmd_addr  = 8'($urandom);
      cmd_len   = 4'($urandom % 6);
      gnt       = (c % 400 < 60) ? 1'b0 : ($urandom % 8 != 0);
      reset     = ($urandom % 600 == 0);
      tick();
    end
    reset = 1'b0;
    cmd_valid = 1'b0;
    gnt = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command queue depth in entries; power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 15: maximum REQ-state cycles spent waiting for gnt before back-off; range 1..255.
REQ-003 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port cmd_valid  input  1  command offered.
REQ-006 Port cmd_ready  output  1  command queue can accept.
REQ-007 Port cmd_addr  input  8  command base address.
REQ-008 Port cmd_len  input  4  beats minus one (0 means 1 beat, 15 means 16 beats).
REQ-009 Port req  output  1  request to arbiter (drives arbiter req_0 or req_1).
REQ-010 Port gnt  input  1  grant from arbiter (gnt_0 or gnt_1).
REQ-011 Port addr_out  output  8  value driven onto the shared address bus.
REQ-012 Port addr_oe  output  1  bus drive enable; the top level tristates the bus when it is 0.
REQ-013 Port beat  output  1  addr_out is a valid beat this cycle.
REQ-014 Port done  output  1  one-cycle pulse: command completed.
REQ-015 Port err_timeout  output  1  one-cycle pulse: grant wait expired.
REQ-016 Port err_abort  output  1  one-cycle pulse: grant lost mid-transfer.

Function
REQ-017 cmd_ready SHALL equal NOT full; push on cmd_valid AND cmd_ready; cmd_ready SHALL be independent of a same-cycle pop.
REQ-018 The FSM states SHALL be IDLE, REQ, XFER, RELEASE, BACKOFF; all outputs SHALL be registered.
REQ-019 IDLE: if queue non-empty -> REQ, with req=1 from the next cycle; otherwise stay in IDLE.
REQ-020 REQ: req=1; wait counter increments each cycle; gnt=1 sampled -> XFER, beat index=0; wait counter reaching TIMEOUT with gnt=0 -> BACKOFF, req=0, err_timeout pulse.
REQ-021 BACKOFF SHALL hold req=0 for exactly 2 cycles, then go to REQ with the same head command, which is not popped.
REQ-022 XFER: addr_oe=1, beat=1, addr_out=(base+index) mod 256 (8-bit wrap), index++ per cycle; total len+1 beats; first beat SHALL appear on the cycle after gnt is sampled.
REQ-023 After the last beat: pop the head entry, done pulse, go to RELEASE.
REQ-024 gnt=0 sampled during XFER SHALL trigger: addr_oe=0 and beat=0 the next cycle, err_abort pulse, no pop, go to RELEASE; the command retries from index 0.
REQ-025 RELEASE: req=0, addr_oe=0 for exactly 1 cycle (mandatory gap for arbiter fairness), then go to IDLE.
REQ-026 addr_oe SHALL never be 1 outside XFER; req SHALL be 0 in IDLE, RELEASE and BACKOFF.
REQ-027 Queue order is FIFO; a push while full is ignored (ready=0), with no state change.

Reset
REQ-028 reset=1 SHALL immediately force the IDLE state, an empty queue and cleared counters, and SHALL drive req, addr_oe, beat, done, err_timeout, err_abort, addr_out to 0 and cmd_ready to 1.
REQ-029 Reset asserted mid-XFER SHALL release the bus asynchronously (addr_oe=0) and discard all queued commands.

Structure
REQ-030 Shared package arb_pkg SHALL hold the state enum, ADDR_W=8, LEN_W=4, and the back-off length 2.
REQ-031 The command queue SHALL be a sub-module cmd_fifo (parameterised width/depth, with full/empty flags); the FSM, counters and address generator live in arb_requester.

Verification
REQ-032 Push {addr=0x10,len=2}, gnt=1 two cycles after req -> addr_out 0x10,0x11,0x12 with beat=1, then done pulse, then 1 cycle req=0.
REQ-033 Push {0xFE,len=3} -> addr_out 0xFE,0xFF,0x00,0x01 (wrap).
REQ-034 Hold gnt=0, TIMEOUT=15 -> err_timeout at cycle 15 of REQ, req=0 for 2 cycles, req re-asserts; then grant -> command completes.
REQ-035 Push {0x40,len=7}, drop gnt after beat 3 -> err_abort, addr_oe=0 next cycle, RELEASE, re-request; on regrant the transfer restarts at 0x40 and runs 8 beats.
REQ-036 Push 5 commands back-to-back with FIFO_DEPTH=4, gnt=0 -> cmd_ready=0 after the 4th push and the 5th is not accepted; after grants, commands complete in push order.
REQ-037 Assert reset during beat 2 of a 4-beat transfer -> all outputs 0 asynchronously, queue empty, cmd_ready=1.
